// File: rtl/fft_r2_ctrl.sv
// In-place radix-2 DIT FFT sequencer: walks every stage/butterfly, issues one
// butterfly read per cycle and replays the read addresses as delayed write-backs.
module fft_r2_ctrl #(
  parameter int N_LOG2   = 3,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [3:0]        stage,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b
);

  localparam int AW  = N_LOG2;
  localparam int KW  = N_LOG2 - 1;
  localparam int DLY = PIPE_LAT + 1;

  localparam logic [KW-1:0] K_LAST     = '1;
  localparam logic [3:0]    S_LAST     = 4'(N_LOG2 - 1);
  localparam logic [3:0]    DRAIN_LAST = 4'(PIPE_LAT);
  localparam logic [3:0]    KW4        = 4'(KW);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    s_q, s_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          busy_d, done_d, rd_en_d;
  logic [AW-1:0] addr_a_d, addr_b_d;
  logic [KW-1:0] tw_d;

  logic [AW-1:0] kx, hx, jx, twx;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    rd_en_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          s_d     = '0;
          rd_en_d = 1'b1;
        end
      end
      RUN: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          k_d     = '0;
          cnt_d   = '0;
        end else begin
          k_d     = k_q + KW'(1);
          rd_en_d = 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          if (s_q == S_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            s_d     = s_q + 4'd1;
            rd_en_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Butterfly k of stage s: group g = k>>s, offset j = k mod 2^s; legs are 2^s apart.
  always_comb begin
    kx       = AW'(k_d);
    hx       = AW'(1) << s_d;
    jx       = kx & (hx - AW'(1));
    twx      = jx << (KW4 - s_d);
    addr_a_d = ((kx >> s_d) << (s_d + 4'd1)) | jx;
    addr_b_d = addr_a_d | hx;
    tw_d     = twx[KW-1:0];
    if (!rd_en_d) begin
      addr_a_d = '0;
      addr_b_d = '0;
      tw_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      s_q       <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      rd_en     <= rd_en_d;
      rd_addr_a <= addr_a_d;
      rd_addr_b <= addr_b_d;
      tw_addr   <= tw_d;
    end
  end

  assign stage = s_q;

  // Write-back shift line: one slot per cycle of RAM read plus datapath latency.
  logic [DLY-1:0] wen_sr;
  logic [AW-1:0]  wa_sr [DLY];
  logic [AW-1:0]  wb_sr [DLY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_sr <= '0;
      for (int i = 0; i < DLY; i++) begin
        wa_sr[i] <= '0;
        wb_sr[i] <= '0;
      end
    end else begin
      wen_sr[0] <= rd_en;
      wa_sr[0]  <= rd_addr_a;
      wb_sr[0]  <= rd_addr_b;
      for (int i = 1; i < DLY; i++) begin
        wen_sr[i] <= wen_sr[i-1];
        wa_sr[i]  <= wa_sr[i-1];
        wb_sr[i]  <= wb_sr[i-1];
      end
    end
  end

  assign wr_en     = wen_sr[DLY-1];
  assign wr_addr_a = wa_sr[DLY-1];
  assign wr_addr_b = wb_sr[DLY-1];

endmodule

// File: tb/tb_fft_r2_ctrl.sv
// Directed bench for fft_r2_ctrl: 8-point transform with PIPE_LAT 2 (main),
// 0 and 5 (hazard/latency), sharing clock, reset and start.
module tb_fft_r2_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic       busy [3];
  logic       done [3];
  logic [3:0] stage [3];
  logic       rd_en [3];
  logic [2:0] rd_a [3];
  logic [2:0] rd_b [3];
  logic [1:0] tw [3];
  logic       wr_en [3];
  logic [2:0] wr_a [3];
  logic [2:0] wr_b [3];

  fft_r2_ctrl #(.N_LOG2(3), .PIPE_LAT(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[0]), .done(done[0]),
    .stage(stage[0]), .rd_en(rd_en[0]), .rd_addr_a(rd_a[0]), .rd_addr_b(rd_b[0]),
    .tw_addr(tw[0]), .wr_en(wr_en[0]), .wr_addr_a(wr_a[0]), .wr_addr_b(wr_b[0]));

  fft_r2_ctrl #(.N_LOG2(3), .PIPE_LAT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[1]), .done(done[1]),
    .stage(stage[1]), .rd_en(rd_en[1]), .rd_addr_a(rd_a[1]), .rd_addr_b(rd_b[1]),
    .tw_addr(tw[1]), .wr_en(wr_en[1]), .wr_addr_a(wr_a[1]), .wr_addr_b(wr_b[1]));

  fft_r2_ctrl #(.N_LOG2(3), .PIPE_LAT(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[2]), .done(done[2]),
    .stage(stage[2]), .rd_en(rd_en[2]), .rd_addr_a(rd_a[2]), .rd_addr_b(rd_b[2]),
    .tw_addr(tw[2]), .wr_en(wr_en[2]), .wr_addr_a(wr_a[2]), .wr_addr_b(wr_b[2]));

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
    logic [3:0] st;
  } ev_t;

  ev_t  vecs [12];
  ev_t  rdq [3][$];
  ev_t  wrq [3][$];
  int   doneq [3][$];
  int   busy_cnt [3];
  logic busy_log [64];
  logic [3:0] stage_log [64];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 3; d++) begin
      rdq[d].delete();
      wrq[d].delete();
      doneq[d].delete();
      busy_cnt[d] = 0;
    end
    for (int c = 0; c < 64; c++) begin
      busy_log[c]  = 1'b0;
      stage_log[c] = 4'd0;
    end
  endtask

  // Cycle c is sampled at its falling edge; start is then driven for the edge ending cycle c.
  task automatic applyStimulus(input int n, input int s1, input int s2, input int s3);
    ev_t e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rd_en[d]) begin
          e.cyc = c; e.a = rd_a[d]; e.b = rd_b[d]; e.tw = tw[d]; e.st = stage[d];
          rdq[d].push_back(e);
        end
        if (wr_en[d]) begin
          e.cyc = c; e.a = wr_a[d]; e.b = wr_b[d]; e.tw = 2'd0; e.st = 4'd0;
          wrq[d].push_back(e);
        end
        if (done[d]) doneq[d].push_back(c);
        if (busy[d]) busy_cnt[d]++;
      end
      if (c < 64) begin
        busy_log[c]  = busy[0];
        stage_log[c] = stage[0];
      end
      start = (c == s1) || (c == s2) || (c == s3);
    end
    start = 1'b0;
  endtask

  task automatic check_zero(input string name);
    for (int d = 0; d < 3; d++)
      check($sformatf("%s dut%0d outputs", name, d),
            int'({busy[d], done[d], stage[d], rd_en[d], rd_a[d], rd_b[d], tw[d],
                  wr_en[d], wr_a[d], wr_b[d]}), 0);
  endtask

  // Full 45-cycle window of the PIPE_LAT=2 instance started at cycle 0.
  task automatic checkOutput(input string name);
    check({name, " rd count"}, rdq[0].size(), 12);
    check({name, " wr count"}, wrq[0].size(), 12);
    check({name, " done count"}, doneq[0].size(), 1);
    if (doneq[0].size() > 0) check({name, " done cycle"}, doneq[0][0], 22);
    for (int i = 0; i < 12; i++) begin
      if (i < rdq[0].size()) begin
        check($sformatf("%s rd%0d cycle", name, i), rdq[0][i].cyc, vecs[i].cyc);
        check($sformatf("%s rd%0d addr_a", name, i), rdq[0][i].a, vecs[i].a);
        check($sformatf("%s rd%0d addr_b", name, i), rdq[0][i].b, vecs[i].b);
        check($sformatf("%s rd%0d tw", name, i), rdq[0][i].tw, vecs[i].tw);
        check($sformatf("%s rd%0d stage", name, i), rdq[0][i].st, vecs[i].st);
      end
      if (i < wrq[0].size()) begin
        check($sformatf("%s wr%0d cycle", name, i), wrq[0][i].cyc, vecs[i].cyc + 3);
        check($sformatf("%s wr%0d addr_a", name, i), wrq[0][i].a, vecs[i].a);
        check($sformatf("%s wr%0d addr_b", name, i), wrq[0][i].b, vecs[i].b);
      end
    end
    for (int c = 0; c < 45; c++)
      check($sformatf("%s busy c%0d", name, c), busy_log[c], (c >= 1 && c <= 22) ? 1 : 0);
    check({name, " stage held after done"}, stage_log[30], 2);
  endtask

  task automatic check_hazard(input int d, input int pl);
    string nm;
    nm = $sformatf("lat%0d", pl);
    check({nm, " rd count"}, rdq[d].size(), 12);
    check({nm, " wr count"}, wrq[d].size(), 12);
    check({nm, " done count"}, doneq[d].size(), 1);
    if (doneq[d].size() > 0) check({nm, " done cycle"}, doneq[d][0], 3 * (4 + pl + 1) + 1);
    if (rdq[d].size() == 12 && wrq[d].size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        check($sformatf("%s wr%0d delay", nm, i), wrq[d][i].cyc - rdq[d][i].cyc, pl + 1);
        check($sformatf("%s wr%0d addr_a", nm, i), wrq[d][i].a, vecs[i].a);
        check($sformatf("%s wr%0d addr_b", nm, i), wrq[d][i].b, vecs[i].b);
      end
      for (int s = 0; s < 2; s++)
        check($sformatf("%s stage%0d read after last write", nm, s + 1),
              (rdq[d][4*s+4].cyc > wrq[d][4*s+3].cyc) ? 1 : 0, 1);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{1,  3'd0, 3'd1, 2'd0, 4'd0};
    vecs[1]  = '{2,  3'd2, 3'd3, 2'd0, 4'd0};
    vecs[2]  = '{3,  3'd4, 3'd5, 2'd0, 4'd0};
    vecs[3]  = '{4,  3'd6, 3'd7, 2'd0, 4'd0};
    vecs[4]  = '{8,  3'd0, 3'd2, 2'd0, 4'd1};
    vecs[5]  = '{9,  3'd1, 3'd3, 2'd2, 4'd1};
    vecs[6]  = '{10, 3'd4, 3'd6, 2'd0, 4'd1};
    vecs[7]  = '{11, 3'd5, 3'd7, 2'd2, 4'd1};
    vecs[8]  = '{15, 3'd0, 3'd4, 2'd0, 4'd2};
    vecs[9]  = '{16, 3'd1, 3'd5, 2'd1, 4'd2};
    vecs[10] = '{17, 3'd2, 3'd6, 2'd2, 4'd2};
    vecs[11] = '{18, 3'd3, 3'd7, 2'd3, 4'd2};

    repeat (3) @(negedge clk);
    check_zero("in reset");
    rst_n = 1'b1;
    clear_logs();
    applyStimulus(50, -1, -1, -1);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("idle dut%0d rd count", d), rdq[d].size(), 0);
      check($sformatf("idle dut%0d wr count", d), wrq[d].size(), 0);
      check($sformatf("idle dut%0d busy cycles", d), busy_cnt[d], 0);
    end
    check_zero("idle");

    $display("[TB] single transform, three latencies");
    clear_logs();
    applyStimulus(45, 0, -1, -1);
    checkOutput("run1");
    check_hazard(1, 0);
    check_hazard(2, 5);

    $display("[TB] start pulses while busy");
    clear_logs();
    applyStimulus(45, 0, 5, 22);
    checkOutput("restart");

    $display("[TB] async reset mid-run");
    clear_logs();
    applyStimulus(10, 0, -1, -1);
    check("pre-reset reading at cycle 9",
          (rdq[0].size() > 0) ? rdq[0][rdq[0].size()-1].cyc : -1, 9);
    rst_n = 1'b0;
    #1;
    check_zero("reset asserted");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    applyStimulus(20, -1, -1, -1);
    check("post-reset rd count", rdq[0].size(), 0);
    check("post-reset wr count", wrq[0].size(), 0);
    check("post-reset busy cycles", busy_cnt[0], 0);
    clear_logs();
    applyStimulus(45, 0, -1, -1);
    checkOutput("after-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_r2_ctrl.md
Name: fft_r2_ctrl

Overview:
In-place radix-2 DIT FFT sequencer that drives one shared butterfly datapath (twiddle multiply + 16-bit butterfly adders) over a single dual-port sample RAM. Walks all stages and butterflies of an N-point transform and issues one butterfly per cycle. Generates RAM read addresses, twiddle ROM index, and delayed write-back addresses/enables matched to the datapath latency. Bit-reversed input loading and output readout are outside this block.

Parameters:
N_LOG2, 3, log2 of transform size N; legal range 2..10
PIPE_LAT, 2, cycles from RAM read data valid to butterfly result valid (twiddle multiply + butterfly); legal range 0..8

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a transform; sampled only in IDLE
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the transform completes
stage  out  4  current stage index s (0..N_LOG2-1)
rd_en  out  1  RAM read strobe for one butterfly
rd_addr_a  out  N_LOG2  upper-leg read address
rd_addr_b  out  N_LOG2  lower-leg read address
tw_addr  out  N_LOG2-1  twiddle ROM index, aligned with rd_en
wr_en  out  1  RAM write strobe for butterfly results
wr_addr_a  out  N_LOG2  upper-leg write address
wr_addr_b  out  N_LOG2  lower-leg write address

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; all outputs 0; k=0, s=0; write delay line cleared. Asserting reset mid-transform aborts the transform with no further rd_en/wr_en.
- States: IDLE, RUN, DRAIN, DONE. All outputs registered.
- IDLE: start=1 -> RUN with s=0, k=0. start=0 -> stay. start is ignored in every other state.
- RUN: rd_en=1 every cycle. Butterfly index k counts 0..N/2-1. With h=2^s, j=k mod h, g=k>>s:
  - rd_addr_a = g*2h + j
  - rd_addr_b = rd_addr_a + h
  - tw_addr = j << (N_LOG2-1-s)
  - Arithmetic is unsigned, width-exact, with no wrap beyond N-1.
  - At k=N/2-1 -> DRAIN and k clears.
- DRAIN: rd_en=0 for exactly PIPE_LAT+1 cycles. This guarantees the last write of stage s lands before the first read of stage s+1; reads never share a cycle with the final write.
  - On exit, if s<N_LOG2-1: s increments and state -> RUN.
  - Otherwise -> DONE.
- DONE: done=1 for one cycle, busy=1 -> IDLE. stage holds N_LOG2-1 until the next start, then resets to 0.
- Write-back timing:
  - RAM read latency is 1 cycle.
  - wr_en, wr_addr_a and wr_addr_b equal rd_en, rd_addr_a and rd_addr_b delayed by exactly PIPE_LAT+1 cycles (shift register).
  - While wr_en=0, wr_addr_a and wr_addr_b are 0.
- Counts:
  - Exactly N_LOG2*N/2 rd_en and wr_en pulses per transform.
  - Cycle count from the start-sampling edge to done = N_LOG2*(N/2+PIPE_LAT+1)+1.
- busy stays high until the DONE cycle inclusive. A start asserted on the same cycle as done is ignored.

Test Plan:
- Reset/idle: hold rst_n=0, then release with start=0 -> all outputs 0, busy=0, no rd_en for 50 cycles.
- N_LOG2=3, PIPE_LAT=2, start pulse at cycle 0:
  - rd_en in cycles 1-4, 8-11 and 15-18; done at cycle 22.
  - Exactly 12 rd_en and 12 wr_en.
  - Each wr_en is 3 cycles after its matching rd_en, with identical addresses.
- Same configuration, address check:
  - Stage 0 (a,b,tw) = (0,1,0),(2,3,0),(4,5,0),(6,7,0).
  - Stage 1 = (0,2,0),(1,3,2),(4,6,0),(5,7,2).
  - Stage 2 = (0,4,0),(1,5,1),(2,6,2),(3,7,3).
- Hazard check with PIPE_LAT=0 and PIPE_LAT=5:
  - No rd_en of stage s+1 occurs on or before the last wr_en of stage s.
  - Done lands at cycle 3*(4+PIPE_LAT+1)+1.
- Start while busy: pulse start again at cycles 5 and 22 -> ignored; exactly one done; 12 writes.
- Async reset mid-RUN: drop rst_n at cycle 9 -> all outputs 0 immediately, no pending wr_en after release; a new start runs a full clean transform.
